// File: rtl/switch_mcu_pipe_seq_if.sv
// Control and status bundle between the decode/EX control and the
// pipeline sequencer of the switch MCU core.
interface switch_mcu_pipe_seq_if;
  logic       in_enable;
  logic       in_branch_taken;
  logic       in_jump;
  logic       in_mem_wait;
  logic       in_irq_req;
  logic       in_flush_stall;
  logic [3:0] out_cycle_cnt;
  logic [1:0] out_flush;
  logic       out_instr_adv;
  logic       out_pc_hold;
  logic       out_irq_ack;
  logic       out_busy;

  modport master (
    output in_enable,
    output in_branch_taken,
    output in_jump,
    output in_mem_wait,
    output in_irq_req,
    output in_flush_stall,
    input  out_cycle_cnt,
    input  out_flush,
    input  out_instr_adv,
    input  out_pc_hold,
    input  out_irq_ack,
    input  out_busy
  );

  modport slave (
    input  in_enable,
    input  in_branch_taken,
    input  in_jump,
    input  in_mem_wait,
    input  in_irq_req,
    input  in_flush_stall,
    output out_cycle_cnt,
    output out_flush,
    output out_instr_adv,
    output out_pc_hold,
    output out_irq_ack,
    output out_busy
  );
endinterface

// File: rtl/switch_mcu_pipe_seq.sv
// Pipeline sequencer: phase counter, flush code, memory-wait freeze
// and interrupt entry scheduling at instruction boundaries.
module switch_mcu_pipe_seq #(
  parameter int CYCLES_PER_INSTR = 5,
  parameter int EX_PHASE         = 2,
  parameter int MEM_PHASE        = 3,
  parameter int IRQ_ENTRY_SLOTS  = 1
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  switch_mcu_pipe_seq_if.slave bus
);

  localparam logic [3:0] LAST_PH = 4'(CYCLES_PER_INSTR - 1);
  localparam logic [3:0] EX_PH   = 4'(EX_PHASE);
  localparam logic [3:0] MEM_PH  = 4'(MEM_PHASE);
  localparam logic [1:0] SLOT_LAST = 2'(IRQ_ENTRY_SLOTS - 1);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] IRQ_WAIT  = 2'd1;
  localparam logic [1:0] IRQ_ENTRY = 2'd2;
  localparam logic [1:0] IRQ_ACK   = 2'd3;

  logic [3:0] cnt;
  logic [1:0] flush;
  logic [1:0] state;
  logic [1:0] state_nx;
  logic [1:0] slot;
  logic       instr_adv;
  logic       irq_ack;
  logic       busy;

  logic freeze;
  logic adv;
  logic wrap;
  logic clean_wrap;

  assign freeze = bus.in_enable & bus.in_mem_wait
                & (cnt == MEM_PH);
  assign adv    = bus.in_enable & ~freeze;
  assign wrap   = adv & (cnt == LAST_PH);

  // IRQ entry only at a boundary with no flush in flight
  assign clean_wrap = wrap & (flush == 2'd0)
                    & ~bus.in_flush_stall;

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == RUN): begin
        if (bus.in_irq_req) state_nx = IRQ_WAIT;
      end
      (state == IRQ_WAIT): begin
        if (!bus.in_irq_req) state_nx = RUN;
        else if (clean_wrap) state_nx = IRQ_ENTRY;
      end
      (state == IRQ_ENTRY): begin
        if (wrap && slot == SLOT_LAST)
          state_nx = IRQ_ACK;
      end
      (state == IRQ_ACK): begin
        state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      cnt <= 4'd0;
    end else if (adv) begin
      cnt <= (cnt == LAST_PH) ? 4'd0 : cnt + 4'd1;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      flush <= 2'd0;
    end else if (adv) begin
      if (cnt == LAST_PH)
        flush <= 2'd0;
      else if (cnt == EX_PH)
        flush <= bus.in_jump         ? 2'd2 :
                 bus.in_branch_taken ? 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state <= RUN;
      slot  <= 2'd0;
    end else if (adv) begin
      state <= state_nx;
      if (state != IRQ_ENTRY)
        slot <= 2'd0;
      else if (wrap)
        slot <= slot + 2'd1;
    end
  end

  // Pulses drop on every clock that does not advance
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      instr_adv <= 1'b0;
      irq_ack   <= 1'b0;
    end else begin
      instr_adv <= wrap & ~bus.in_flush_stall
                 & ((state == RUN) | (state == IRQ_WAIT));
      irq_ack   <= adv & (state != IRQ_ACK)
                 & (state_nx == IRQ_ACK);
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      busy <= 1'b0;
    end else if (bus.in_enable) begin
      busy <= freeze
            | ((adv ? state_nx : state) != RUN);
    end
  end

  assign bus.out_cycle_cnt = cnt;
  assign bus.out_flush     = flush;
  assign bus.out_instr_adv = instr_adv;
  assign bus.out_irq_ack   = irq_ack;
  assign bus.out_busy      = busy;
  assign bus.out_pc_hold   = bus.in_flush_stall
                           | (state == IRQ_ENTRY)
                           | (state == IRQ_ACK);

endmodule

// File: tb/tb_switch_mcu_pipe_seq.sv
// Directed scoreboard bench for the pipeline sequencer.
// Expected outputs are queued per step and popped after each clock.
module tb_switch_mcu_pipe_seq;

  typedef struct packed {
    logic [3:0] c;
    logic [1:0] f;
    logic       a;
    logic       h;
    logic       k;
    logic       b;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  switch_mcu_pipe_seq_if bus ();

  switch_mcu_pipe_seq #(
    .CYCLES_PER_INSTR(5),
    .EX_PHASE(2),
    .MEM_PHASE(3),
    .IRQ_ENTRY_SLOTS(1)
  ) dut (
    .in_clk(clk),
    .in_rst(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string fld,
                     input logic [3:0] got,
                     input logic [3:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s %s got %0d want %0d",
             tag, fld, got, want);
    end
  endtask

  task automatic now(input string tag,
                     input logic [3:0] c, input logic [1:0] f,
                     input logic a, input logic h,
                     input logic k, input logic b);
    exp_t e;
    exp_q.push_back('{c, f, a, h, k, b});
    e = exp_q.pop_front();
    chk(tag, "cnt", bus.out_cycle_cnt, e.c);
    chk(tag, "flush", {2'b0, bus.out_flush}, {2'b0, e.f});
    chk(tag, "adv", {3'b0, bus.out_instr_adv}, {3'b0, e.a});
    chk(tag, "hold", {3'b0, bus.out_pc_hold}, {3'b0, e.h});
    chk(tag, "ack", {3'b0, bus.out_irq_ack}, {3'b0, e.k});
    chk(tag, "busy", {3'b0, bus.out_busy}, {3'b0, e.b});
  endtask

  task automatic cyc(input string tag,
                     input logic [3:0] c, input logic [1:0] f,
                     input logic a, input logic h,
                     input logic k, input logic b);
    @(posedge clk);
    #1;
    now(tag, c, f, a, h, k, b);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.in_enable       = 1'b0;
    bus.in_branch_taken = 1'b0;
    bus.in_jump         = 1'b0;
    bus.in_mem_wait     = 1'b0;
    bus.in_irq_req      = 1'b0;
    bus.in_flush_stall  = 1'b0;
    #12;
    now("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_enable = 1'b1;

    // free run: wrap every 5 clocks
    for (int i = 1; i <= 12; i++)
      cyc("run", 4'(i % 5), 0, (i % 5) == 0, 0, 0, 0);

    // jump wins over branch
    bus.in_jump = 1'b1;
    bus.in_branch_taken = 1'b1;
    cyc("jmp3", 3, 2, 0, 0, 0, 0);
    bus.in_jump = 1'b0;
    bus.in_branch_taken = 1'b0;
    cyc("jmp4", 4, 2, 0, 0, 0, 0);
    cyc("jmp0", 0, 0, 1, 0, 0, 0);
    cyc("jmp1", 1, 0, 0, 0, 0, 0);
    cyc("jmp2", 2, 0, 0, 0, 0, 0);
    bus.in_branch_taken = 1'b1;
    cyc("br3", 3, 1, 0, 0, 0, 0);
    bus.in_branch_taken = 1'b0;
    cyc("br4", 4, 1, 0, 0, 0, 0);
    cyc("br0", 0, 0, 1, 0, 0, 0);
    cyc("br1", 1, 0, 0, 0, 0, 0);
    bus.in_jump = 1'b1;
    cyc("jlate2", 2, 0, 0, 0, 0, 0);
    bus.in_jump = 1'b0;
    cyc("jlate3", 3, 0, 0, 0, 0, 0);
    cyc("jlate4", 4, 0, 0, 0, 0, 0);
    cyc("jlate0", 0, 0, 1, 0, 0, 0);

    // memory wait freeze in MEM phase only
    cyc("mw1", 1, 0, 0, 0, 0, 0);
    cyc("mw2", 2, 0, 0, 0, 0, 0);
    cyc("mw3", 3, 0, 0, 0, 0, 0);
    bus.in_mem_wait = 1'b1;
    cyc("frz_a", 3, 0, 0, 0, 0, 1);
    cyc("frz_b", 3, 0, 0, 0, 0, 1);
    cyc("frz_c", 3, 0, 0, 0, 0, 1);
    bus.in_mem_wait = 1'b0;
    cyc("frz4", 4, 0, 0, 0, 0, 0);
    cyc("frz0", 0, 0, 1, 0, 0, 0);
    cyc("nf1", 1, 0, 0, 0, 0, 0);
    bus.in_mem_wait = 1'b1;
    cyc("nf2", 2, 0, 0, 0, 0, 0);
    bus.in_mem_wait = 1'b0;
    cyc("nf3", 3, 0, 0, 0, 0, 0);
    cyc("nf4", 4, 0, 0, 0, 0, 0);
    cyc("nf0", 0, 0, 1, 0, 0, 0);

    // irq deferred past a flushed instruction
    cyc("iq1", 1, 0, 0, 0, 0, 0);
    bus.in_irq_req = 1'b1;
    cyc("iw2", 2, 0, 0, 0, 0, 1);
    bus.in_branch_taken = 1'b1;
    cyc("iw3", 3, 1, 0, 0, 0, 1);
    bus.in_branch_taken = 1'b0;
    cyc("iw4", 4, 1, 0, 0, 0, 1);
    cyc("iw0", 0, 0, 1, 0, 0, 1);
    for (int i = 1; i <= 4; i++)
      cyc("iwb", 4'(i), 0, 0, 0, 0, 1);
    cyc("ie0", 0, 0, 1, 1, 0, 1);
    for (int i = 1; i <= 4; i++)
      cyc("ie", 4'(i), 0, 0, 1, 0, 1);
    cyc("iack", 0, 0, 0, 1, 1, 1);
    bus.in_irq_req = 1'b0;
    cyc("irun", 1, 0, 0, 0, 0, 0);

    // short irq pulse is dropped without ack
    bus.in_irq_req = 1'b1;
    cyc("ip2", 2, 0, 0, 0, 0, 1);
    cyc("ip3", 3, 0, 0, 0, 0, 1);
    bus.in_irq_req = 1'b0;
    cyc("ip4", 4, 0, 0, 0, 0, 0);
    cyc("ip0", 0, 0, 1, 0, 0, 0);

    // flush stall: combinational hold, no retire
    cyc("st1", 1, 0, 0, 0, 0, 0);
    cyc("st2", 2, 0, 0, 0, 0, 0);
    cyc("st3", 3, 0, 0, 0, 0, 0);
    cyc("st4", 4, 0, 0, 0, 0, 0);
    bus.in_flush_stall = 1'b1;
    #1;
    now("st_hold", 4, 0, 0, 1, 0, 0);
    cyc("st0", 0, 0, 0, 1, 0, 0);
    bus.in_flush_stall = 1'b0;
    #1;
    now("st_rel", 0, 0, 0, 0, 0, 0);

    // reset in the middle of irq entry
    bus.in_irq_req = 1'b1;
    cyc("rw1", 1, 0, 0, 0, 0, 1);
    cyc("rw2", 2, 0, 0, 0, 0, 1);
    cyc("rw3", 3, 0, 0, 0, 0, 1);
    cyc("rw4", 4, 0, 0, 0, 0, 1);
    cyc("re0", 0, 0, 1, 1, 0, 1);
    bus.in_irq_req = 1'b0;
    cyc("re1", 1, 0, 0, 1, 0, 1);
    cyc("re2", 2, 0, 0, 1, 0, 1);
    rst_n = 1'b0;
    #1;
    now("rst_mid", 0, 0, 0, 0, 0, 0);
    cyc("rst_hold", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc("rr1", 1, 0, 0, 0, 0, 0);

    // enable low holds counter and flush
    bus.in_branch_taken = 1'b1;
    cyc("en2", 2, 0, 0, 0, 0, 0);
    cyc("en3", 3, 1, 0, 0, 0, 0);
    bus.in_branch_taken = 1'b0;
    bus.in_enable = 1'b0;
    cyc("dis_a", 3, 1, 0, 0, 0, 0);
    cyc("dis_b", 3, 1, 0, 0, 0, 0);
    bus.in_enable = 1'b1;
    cyc("en4", 4, 1, 0, 0, 0, 0);
    cyc("en0", 0, 0, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
